icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the instruction-fetch stage (upstream) and the memory controller (downstream).
- Serves 32-bit fetches from local storage on a hit.
- On a miss, issues one word-fetch request to the memory controller, writes the returned word into the line, and forwards it to fetch.
- Fetch flush (branch/mispredict) cancels delivery of an in-flight result without corrupting the array.

---
 rtl/icache_direct_if.sv | 25 ++
 rtl/icache_direct.sv | 120 ++++++++++++
 tb/tb_icache_direct.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - fetch-side and memory-controller-side signal bundle for icache_direct
interface icache_direct_if #(
  parameter int ADDR_W = 32
);
  logic              iIF_en;
  logic [ADDR_W-1:0] iIF_addr;
  logic              iIF_flush;
  logic              oIF_valid;
  logic [31:0]       oIF_inst;
  logic              oIF_busy;
  logic              oMC_en;
  logic [ADDR_W-1:0] oMC_addr;
  logic              iMC_done;
  logic [31:0]       iMC_inst;

  modport slave (
    input  iIF_en, iIF_addr, iIF_flush, iMC_done, iMC_inst,
    output oIF_valid, oIF_inst, oIF_busy, oMC_en, oMC_addr
  );

  modport master (
    output iIF_en, iIF_addr, iIF_flush, iMC_done, iMC_inst,
    input  oIF_valid, oIF_inst, oIF_busy, oMC_en, oMC_addr
  );
endinterface

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache, one word per line
// Optional hit/miss counters enabled with ICACHE_STAT_EN.
module icache_direct #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  icache_direct_if.slave        bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]           oSTAT_hit,
  output logic [31:0]           oSTAT_miss
`endif
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2
  } state_t;

  state_t             state;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               cancel;
  logic [LINES-1:0]   valid_bits;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;

  logic [INDEX_W-1:0] acc_index;
  logic [TAG_W-1:0]   acc_tag;
  logic               lookup_hit;

  assign acc_index  = bus.iIF_addr[INDEX_W+1:2];
  assign acc_tag    = bus.iIF_addr[ADDR_W-1:INDEX_W+2];
  assign lookup_hit = rd_valid && (rd_tag == req_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_index     <= '0;
      req_tag       <= '0;
      cancel        <= 1'b0;
      valid_bits    <= '0;
      rd_valid      <= 1'b0;
      rd_tag        <= '0;
      rd_data       <= '0;
      bus.oIF_valid <= 1'b0;
      bus.oIF_inst  <= '0;
      bus.oIF_busy  <= 1'b0;
      bus.oMC_en    <= 1'b0;
      bus.oMC_addr  <= '0;
`ifdef ICACHE_STAT_EN
      oSTAT_hit     <= '0;
      oSTAT_miss    <= '0;
`endif
    end else if (rdy) begin
      // rdy low freezes everything, which also stretches an oIF_valid pulse
      bus.oIF_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iIF_en && !bus.iIF_flush) begin
            req_index    <= acc_index;
            req_tag      <= acc_tag;
            rd_valid     <= valid_bits[acc_index];
            rd_tag       <= tag_mem[acc_index];
            rd_data      <= data_mem[acc_index];
            cancel       <= 1'b0;
            bus.oIF_busy <= 1'b1;
            state        <= LOOKUP;
          end
        end
        LOOKUP: begin
`ifdef ICACHE_STAT_EN
          if (lookup_hit) oSTAT_hit <= oSTAT_hit + 32'd1;
          else            oSTAT_miss <= oSTAT_miss + 32'd1;
`endif
          if (bus.iIF_flush) begin
            bus.oIF_busy <= 1'b0;
            state        <= IDLE;
          end else if (lookup_hit) begin
            bus.oIF_valid <= 1'b1;
            bus.oIF_inst  <= rd_data;
            bus.oIF_busy  <= 1'b0;
            state         <= IDLE;
          end else begin
            bus.oMC_en   <= 1'b1;
            bus.oMC_addr <= {req_tag, req_index, 2'b00};
            state        <= MISS;
          end
        end
        MISS: begin
          // The transfer always completes and fills the line; a flush only mutes delivery
          if (bus.iMC_done) begin
            data_mem[req_index]   <= bus.iMC_inst;
            tag_mem[req_index]    <= req_tag;
            valid_bits[req_index] <= 1'b1;
            bus.oMC_en            <= 1'b0;
            bus.oIF_busy          <= 1'b0;
            state                 <= IDLE;
            if (!cancel && !bus.iIF_flush) begin
              bus.oIF_valid <= 1'b1;
              bus.oIF_inst  <= bus.iMC_inst;
            end
          end else if (bus.iIF_flush) begin
            cancel <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - randomized self-checking bench for icache_direct against a line-map model
module tb_icache_direct;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  icache_direct_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_STAT_EN
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;
  int unsigned exp_hit  = 0;
  int unsigned exp_miss = 0;
`endif

  icache_direct #(.INDEX_W(6), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
`ifdef ICACHE_STAT_EN
    ,
    .oSTAT_hit  (stat_hit),
    .oSTAT_miss (stat_miss)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: which word address each index currently holds; memory contents are a fixed function
  logic [31:0] ref_line [int];
  logic [31:0] last_inst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h100) return 32'h00A00093;
    return (w * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // mode: 0 plain, 1 flush in LOOKUP, 2 flush during MISS, 3 flush with done,
  //       4 rdy low 3 cycles in LOOKUP, 5 rdy low 2 cycles during the valid pulse
  task automatic fetch(input logic [31:0] a, input int lat, input int mode);
    int idx;
    logic [31:0] wa;
    bit hit;
    bit deliver;
    wa  = {a[31:2], 2'b00};
    idx = int'(a[7:2]);
    hit = ref_line.exists(idx) && (ref_line[idx] == wa);
    check("idle_before_req", bus.oIF_busy, 1'b0);
    bus.iIF_en   = 1'b1;
    bus.iIF_addr = a;
    tick();
    bus.iIF_en = 1'b0;
    check("busy_on_accept", bus.oIF_busy, 1'b1);
    check("no_valid_on_accept", bus.oIF_valid, 1'b0);
`ifdef ICACHE_STAT_EN
    if (hit) exp_hit++; else exp_miss++;
`endif
    if (mode == 1) begin
      bus.iIF_flush = 1'b1;
      tick();
      bus.iIF_flush = 1'b0;
      check("lookup_flush_valid", bus.oIF_valid, 1'b0);
      check("lookup_flush_busy", bus.oIF_busy, 1'b0);
      check("lookup_flush_mc_en", bus.oMC_en, 1'b0);
      return;
    end
    if (mode == 4) begin
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("stall_no_valid", bus.oIF_valid, 1'b0);
        check("stall_no_mc_en", bus.oMC_en, 1'b0);
        check("stall_busy", bus.oIF_busy, 1'b1);
      end
      rdy = 1'b1;
    end
    tick();
    if (hit) begin
      check("hit_valid", bus.oIF_valid, 1'b1);
      check("hit_inst", bus.oIF_inst, mem_word(a));
      check("hit_mc_en", bus.oMC_en, 1'b0);
      check("hit_busy", bus.oIF_busy, 1'b0);
      last_inst = mem_word(a);
      if (mode == 5) begin
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
          tick();
          check("pulse_held", bus.oIF_valid, 1'b1);
        end
        rdy = 1'b1;
      end
      tick();
      check("hit_pulse_end", bus.oIF_valid, 1'b0);
      check("hit_inst_hold", bus.oIF_inst, last_inst);
      return;
    end
    check("miss_mc_en", bus.oMC_en, 1'b1);
    check("miss_mc_addr", bus.oMC_addr, wa);
    check("miss_no_valid", bus.oIF_valid, 1'b0);
    for (int i = 0; i < lat; i++) begin
      if (mode == 2 && i == 0) bus.iIF_flush = 1'b1;
      bus.iIF_en   = 1'($urandom_range(0, 1));
      bus.iIF_addr = $urandom;
      tick();
      bus.iIF_flush = 1'b0;
      check("wait_mc_en", bus.oMC_en, 1'b1);
      check("wait_mc_addr", bus.oMC_addr, wa);
      check("wait_no_valid", bus.oIF_valid, 1'b0);
      check("wait_busy", bus.oIF_busy, 1'b1);
    end
    bus.iMC_done = 1'b1;
    bus.iMC_inst = mem_word(a);
    if (mode == 3) bus.iIF_flush = 1'b1;
    tick();
    bus.iMC_done  = 1'b0;
    bus.iIF_flush = 1'b0;
    bus.iIF_en    = 1'b0;
    bus.iMC_inst  = $urandom;
    deliver = !(mode == 2 || mode == 3);
    check("done_valid", bus.oIF_valid, deliver);
    if (deliver) last_inst = mem_word(a);
    check("done_inst", bus.oIF_inst, last_inst);
    check("done_mc_en", bus.oMC_en, 1'b0);
    check("done_busy", bus.oIF_busy, 1'b0);
    ref_line[idx] = wa;
    tick();
    check("done_pulse_end", bus.oIF_valid, 1'b0);
  endtask

  task automatic idle_flush_req(input logic [31:0] a);
    bus.iIF_en    = 1'b1;
    bus.iIF_flush = 1'b1;
    bus.iIF_addr  = a;
    tick();
    bus.iIF_en    = 1'b0;
    bus.iIF_flush = 1'b0;
    check("idle_flush_not_accepted", bus.oIF_busy, 1'b0);
    tick();
    check("idle_flush_no_valid", bus.oIF_valid, 1'b0);
    check("idle_flush_no_mc", bus.oMC_en, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    rst           = 1'b1;
    rdy           = 1'b1;
    bus.iIF_en    = 1'b0;
    bus.iIF_addr  = '0;
    bus.iIF_flush = 1'b0;
    bus.iMC_done  = 1'b0;
    bus.iMC_inst  = '0;
    last_inst     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", bus.oIF_valid, 1'b0);
    check("rst_inst", bus.oIF_inst, 32'h0);
    check("rst_busy", bus.oIF_busy, 1'b0);
    check("rst_mc_en", bus.oMC_en, 1'b0);
    check("rst_mc_addr", bus.oMC_addr, 32'h0);

    fetch(32'h100, 5, 0);
    fetch(32'h100, 0, 0);
    fetch(32'h200, 3, 0);
    fetch(32'h100, 2, 0);
    fetch(32'h300, 4, 2);
    fetch(32'h300, 0, 0);
    fetch(32'h300, 0, 4);
    fetch(32'h300, 0, 5);
    fetch(32'h504, 2, 3);
    fetch(32'h506, 0, 0);
    fetch(32'h704, 1, 1);
    idle_flush_req(32'h100);

    // Reset in the middle of a miss: valid bits are lost, so the same line misses again
    bus.iIF_en   = 1'b1;
    bus.iIF_addr = 32'h400;
    tick();
    bus.iIF_en = 1'b0;
    tick();
    check("pre_rst_mc_en", bus.oMC_en, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_mc_en", bus.oMC_en, 1'b0);
    check("mid_rst_busy", bus.oIF_busy, 1'b0);
    check("mid_rst_inst", bus.oIF_inst, 32'h0);
    ref_line.delete();
    last_inst = '0;
`ifdef ICACHE_STAT_EN
    exp_hit  = 0;
    exp_miss = 0;
`endif
    fetch(32'h400, 3, 0);
    fetch(32'h100, 1, 0);

    for (int n = 0; n < 250; n++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 31)
          | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      fetch(a, $urandom_range(1, 6), $urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) idle_flush_req($urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end

`ifdef ICACHE_STAT_EN
    check("stat_hit", stat_hit, exp_hit);
    check("stat_miss", stat_miss, exp_miss);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
